// File: rtl/oe_bcm_timer.sv
// Binary-code-modulation output-enable timer: blank guard, plane-weighted ON time, OFF remainder.
// Define OE_BCM_DIMMING_EN to scale the ON time by dim_level; otherwise the whole plane period is ON.
module oe_bcm_timer #(
    parameter int                          BRIGHTNESS_WIDTH = 6,
    parameter int                          BASE_TICKS_WIDTH = 8,
    parameter logic [BASE_TICKS_WIDTH-1:0] BASE_TICKS       = 8'd4,
    parameter logic [3:0]                  BLANK_TICKS      = 4'd2
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        latch_strobe,
    input  logic [BRIGHTNESS_WIDTH-1:0] brightness_mask,
    input  logic [7:0]                  dim_level,
    output logic                        output_enable,
    output logic                        busy,
    output logic                        plane_done,
    output logic [2:0]                  plane_index
);

    localparam int TW = BASE_TICKS_WIDTH + BRIGHTNESS_WIDTH;
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_TICKS) - TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON,
        ST_OFF
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] on_q, on_d;
    logic [TW-1:0] off_q, off_d;
    logic [2:0]    idx_q, idx_d;
    logic          oe_q, busy_q, done_q;
    logic          done_d;

    logic [2:0]    idx_c;
    logic [TW-1:0] total_c;
    logic [TW-1:0] on_c;
    logic [TW-1:0] off_c;
    logic          capture_c;

    // Lowest set bit wins for multi-hot masks.
    always_comb begin
        idx_c = '0;
        for (int i = BRIGHTNESS_WIDTH - 1; i >= 0; i--) begin
            if (brightness_mask[i]) idx_c = 3'(i);
        end
    end

    assign total_c   = TW'(BASE_TICKS) << idx_c;
    assign capture_c = latch_strobe && (|brightness_mask);

`ifdef OE_BCM_DIMMING_EN
    logic [TW+7:0] prod_c;
    assign prod_c = (TW+8)'(total_c) * (TW+8)'({1'b0, dim_level} + 9'd1);
    assign on_c   = TW'(prod_c >> 8);
    assign off_c  = total_c - on_c;
`else
    logic unused_dim;
    assign unused_dim = ^dim_level;
    assign on_c       = total_c;
    assign off_c      = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        off_d   = off_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        // A valid strobe always wins, including an abort of a running plane.
        if (capture_c) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            on_d    = on_c;
            off_d   = off_c;
            idx_d   = idx_c;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end else if (on_q != '0) begin
                        state_d = ST_ON;
                        cnt_d   = on_q - TW'(1);
                    end else if (off_q != '0) begin
                        state_d = ST_OFF;
                        cnt_d   = off_q - TW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end else if (off_q != '0) begin
                        state_d = ST_OFF;
                        cnt_d   = off_q - TW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            on_q    <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            oe_q    <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
        end
    end

    assign output_enable = oe_q;
    assign busy          = busy_q;
    assign plane_done    = done_q;
    assign plane_index   = idx_q;

endmodule

// File: tb/tb_oe_bcm_timer.sv
// Bench for oe_bcm_timer: directed plane scenarios plus random strobes against a cycle-window model.
// Follows OE_BCM_DIMMING_EN the same way the design does.
module tb_oe_bcm_timer;

    localparam int BW    = 6;
    localparam int BASE  = 4;
    localparam int BLANK = 2;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          latch_strobe;
    logic [BW-1:0] brightness_mask;
    logic [7:0]    dim_level;
    logic          output_enable;
    logic          busy;
    logic          plane_done;
    logic [2:0]    plane_index;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: last accepted capture and the plane it describes.
    bit have_cap = 1'b0;
    int cap_cyc  = 0;
    int m_total  = 0;
    int m_on     = 0;
    int m_idx    = 0;

    oe_bcm_timer #(
        .BRIGHTNESS_WIDTH(BW),
        .BASE_TICKS_WIDTH(8),
        .BASE_TICKS(8'd4),
        .BLANK_TICKS(4'd2)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .latch_strobe   (latch_strobe),
        .brightness_mask(brightness_mask),
        .dim_level      (dim_level),
        .output_enable  (output_enable),
        .busy           (busy),
        .plane_done     (plane_done),
        .plane_index    (plane_index)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_idx(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // A plane captured at cycle s: busy over s+1..s+BLANK+total, OE over
    // s+1+BLANK..s+BLANK+on, done pulse at s+1+BLANK+total.
    task automatic check_cycle();
        int   rel;
        logic e_oe   = 1'b0;
        logic e_busy = 1'b0;
        logic e_done = 1'b0;
        logic [2:0] e_idx = 3'd0;
        if (have_cap) begin
            rel    = cyc - cap_cyc;
            e_busy = (rel >= 1) && (rel <= BLANK + m_total);
            e_oe   = (rel >= 1 + BLANK) && (rel <= BLANK + m_on);
            e_done = (rel == 1 + BLANK + m_total);
            e_idx  = 3'(m_idx);
        end
        check_bit("output_enable", output_enable, e_oe);
        check_bit("busy", busy, e_busy);
        check_bit("plane_done", plane_done, e_done);
        check_idx("plane_index", plane_index, e_idx);
    endtask

    task automatic capture(input logic [BW-1:0] m, input logic [7:0] d);
        int idx = -1;
        for (int i = 0; i < BW; i++) begin
            if (m[i] && idx < 0) idx = i;
        end
        m_idx   = idx;
        m_total = BASE * (1 << idx);
`ifdef OE_BCM_DIMMING_EN
        m_on    = (m_total * (int'(d) + 1)) / 256;
`else
        m_on    = m_total;
`endif
        cap_cyc  = cyc;
        have_cap = 1'b1;
    endtask

    // One clock cycle: check this cycle's outputs, drive this cycle's inputs, advance.
    task automatic step(input logic s, input logic [BW-1:0] m, input logic [7:0] d);
        check_cycle();
        latch_strobe    = s;
        brightness_mask = m;
        dim_level       = d;
        if (s && (m != '0)) capture(m, d);
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    initial begin
        logic          rs;
        logic [BW-1:0] rm;
        int            sel;

        reset           = 1'b1;
        latch_strobe    = 1'b0;
        brightness_mask = '0;
        dim_level       = 8'd0;
        @(posedge clk_in);
        #1;
        check_cycle();
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // Plane 0 at full brightness.
        step(1'b1, 6'b000001, 8'd255);
        repeat (9) step(1'b0, '0, 8'd0);

        // Plane 5 at half duty.
        step(1'b1, 6'b100000, 8'd127);
        repeat (134) step(1'b0, '0, 8'd0);

        // Zero duty: OE stays low for the whole period.
        step(1'b1, 6'b000001, 8'd0);
        repeat (9) step(1'b0, '0, 8'd0);

        // Abort plane 2 at cycle 5 with a plane 0 recapture.
        step(1'b1, 6'b000100, 8'd255);
        repeat (4) step(1'b0, '0, 8'd0);
        step(1'b1, 6'b000001, 8'd255);
        repeat (10) step(1'b0, '0, 8'd0);

        // Plane 1 with no dimming effect expected when the feature is off.
        step(1'b1, 6'b000010, 8'd0);
        repeat (12) step(1'b0, '0, 8'd0);

        // Back-to-back: new strobe in the plane_done cycle.
        step(1'b1, 6'b000001, 8'd255);
        repeat (6) step(1'b0, '0, 8'd0);
        step(1'b1, 6'b000010, 8'd200);
        repeat (14) step(1'b0, '0, 8'd0);

        // Multi-hot mask, then a zero-mask strobe mid-plane that must be ignored.
        step(1'b1, 6'b101100, 8'd180);
        repeat (3) step(1'b0, '0, 8'd0);
        step(1'b1, 6'b000000, 8'd5);
        repeat (20) step(1'b0, '0, 8'd0);

        // dim_level wiggles mid-plane must not matter.
        step(1'b1, 6'b001000, 8'd100);
        repeat (40) step(1'b0, '0, 8'($urandom_range(0, 255)));

        // Asynchronous reset in the middle of ON.
        step(1'b1, 6'b000100, 8'd255);
        repeat (4) step(1'b0, '0, 8'd0);
        check_cycle();
        #2;
        reset = 1'b1;
        #1;
        check_bit("rst_async_oe", output_enable, 1'b0);
        check_bit("rst_async_busy", busy, 1'b0);
        check_bit("rst_async_done", plane_done, 1'b0);
        check_idx("rst_async_idx", plane_index, 3'd0);
        have_cap = 1'b0;
        @(posedge clk_in);
        #1;
        cyc++;
        reset = 1'b0;
        step(1'b1, 6'b000000, 8'd255);
        repeat (8) step(1'b0, '0, 8'd0);

        // Random strobes, masks and dim levels.
        for (int k = 0; k < 2000; k++) begin
            rs  = ($urandom_range(0, 29) == 0);
            sel = $urandom_range(0, 3);
            if (sel == 0)      rm = '0;
            else if (sel == 1) rm = BW'(1) << $urandom_range(0, BW - 1);
            else               rm = BW'($urandom_range(0, 63));
            step(rs, rm, 8'($urandom_range(0, 255)));
        end
        repeat (140) step(1'b0, '0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
